// File: rtl/cpu_pkg.sv
// cpu_pkg
// Shared definitions for the 9-bit CPU fetch stage.
//   PC_W    : program counter / branch-target width, shared with the
//             instruction ROM and the branch-target LUT
//   state_t : run/halt state of the PC sequencer
package cpu_pkg;

    localparam int PC_W = 12;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

endpackage : cpu_pkg

// File: rtl/pc_next_calc.sv
// pc_next_calc
// Combinational next-PC selection for a non-stalled RUN cycle.
// Ports:
//   prog_ctr     in  [D-1:0]  current PC
//   target       in  [D-1:0]  branch-target LUT word (signed when relative)
//   branch_taken in  1        decoded branch with a true condition
//   branch_abs   in  1        1 = absolute target, 0 = PC-relative offset
//   next_pc      out [D-1:0]  PC to load if the cycle is not stalled
module pc_next_calc
    import cpu_pkg::*;
#(
    parameter int D = PC_W
) (
    input  logic [D-1:0] prog_ctr,
    input  logic [D-1:0] target,
    input  logic         branch_taken,
    input  logic         branch_abs,
    output logic [D-1:0] next_pc
);

    localparam logic [D-1:0] ONE = {{(D-1){1'b0}}, 1'b1};

    // A relative target is a signed D-bit offset. Because the sum is kept
    // modulo 2^D, a plain D-bit add of the two's complement word gives the
    // same result as sign-extending and truncating, so no wider adder is
    // needed and wrap-around in either direction is silent.
    always_comb begin
        next_pc = prog_ctr + ONE;
        if (branch_taken) begin
            if (branch_abs) begin
                next_pc = target;
            end else begin
                next_pc = prog_ctr + target;
            end
        end
    end

endmodule : pc_next_calc

// File: rtl/pc_sequencer.sv
// pc_sequencer
// Program-counter sequencer for the CPU fetch stage: owns the PC register,
// the IDLE/RUN/HALT state machine and a saturating retired-instruction count.
// Ports:
//   Clk          in   1     clock, rising edge
//   Reset        in   1     synchronous, active-high
//   start        in   1     launch program from PC 0 (IDLE/HALT only)
//   halt_req     in   1     decoded halt at current PC
//   stall        in   1     fetch not ready, hold PC this cycle
//   branch_taken in   1     decoded branch with a true condition
//   branch_abs   in   1     1 = absolute target, 0 = relative offset
//   target       in   D     branch-target LUT word
//   prog_ctr     out  D     current PC, registered
//   fetch_en     out  1     instruction at prog_ctr consumed this cycle
//   running      out  1     state == RUN
//   done         out  1     state == HALT
//   instr_cnt    out  CW    retired instruction count, registered
module pc_sequencer
    import cpu_pkg::*;
#(
    parameter int D  = PC_W,
    parameter int CW = 16
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          start,
    input  logic          halt_req,
    input  logic          stall,
    input  logic          branch_taken,
    input  logic          branch_abs,
    input  logic [D-1:0]  target,
    output logic [D-1:0]  prog_ctr,
    output logic          fetch_en,
    output logic          running,
    output logic          done,
    output logic [CW-1:0] instr_cnt
);

    localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_MAX = '1;

    state_t        state_q, state_d;
    logic [D-1:0]  pc_d;
    logic [CW-1:0] cnt_d;
    logic [CW-1:0] cnt_inc;
    logic [D-1:0]  calc_pc;

    pc_next_calc #(.D(D)) u_next (
        .prog_ctr     (prog_ctr),
        .target       (target),
        .branch_taken (branch_taken),
        .branch_abs   (branch_abs),
        .next_pc      (calc_pc)
    );

    // Retired count saturates rather than wrapping.
    assign cnt_inc = (instr_cnt == CNT_MAX) ? instr_cnt : instr_cnt + CNT_ONE;

    // Next-state, next-PC and next-count selection. A stall outranks a halt
    // in practice: the halt is simply not seen that cycle and the decoder
    // presents it again, so stall is tested first.
    always_comb begin
        state_d = state_q;
        pc_d    = prog_ctr;
        cnt_d   = instr_cnt;
        unique case (state_q)
            IDLE, HALT: begin
                if (start) begin
                    state_d = RUN;
                    pc_d    = '0;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                if (!stall) begin
                    cnt_d = cnt_inc;
                    if (halt_req) begin
                        state_d = HALT;
                    end else begin
                        pc_d = calc_pc;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                pc_d    = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // State, PC and counter registers; reset wins over everything.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= IDLE;
            prog_ctr  <= '0;
            instr_cnt <= '0;
        end else begin
            state_q   <= state_d;
            prog_ctr  <= pc_d;
            instr_cnt <= cnt_d;
        end
    end

    assign running  = (state_q == RUN);
    assign done     = (state_q == HALT);
    assign fetch_en = running & ~stall;

endmodule : pc_sequencer
